pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_if.sv | 47 ++++
 rtl/pipe_ctrl_perf.sv | 40 ++++
 rtl/pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control encodings: jump causes, hold levels and bus widths.
package pipe_ctrl_pkg;

  localparam int unsigned JUMP_CAUSE_W = 3;
  localparam int unsigned HOLDPIP_W    = 2;

  typedef enum logic [JUMP_CAUSE_W-1:0] {
    JC_NO                 = 3'd0,
    JC_PREDICT_NO_BUT_YES = 3'd1,
    JC_PREDICT_YES_BUT_NO = 3'd2,
    JC_NOCONDITION        = 3'd3,
    JC_INTERRUPT          = 3'd4,
    JC_EXCEPTION          = 3'd5
  } jump_cause_e;

  typedef enum logic [HOLDPIP_W-1:0] {
    HOLD_NO  = 2'd0,
    HOLD_IF  = 2'd1,
    HOLD_ID  = 2'd2,
    HOLD_ALL = 2'd3
  } hold_e;

  function automatic logic is_mispredict(input jump_cause_e c);
    return (c == JC_PREDICT_NO_BUT_YES) || (c == JC_PREDICT_YES_BUT_NO);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Redirect/stall bundle between pipe_ctrl and the rest of the core.
// master: the flow controller; slave: EX/CSR/CLINT/LSU/PC side.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  jump_cause_e ex_jump_cause_i;
  logic [31:0] ex_jump_from_i;
  logic [31:0] ex_jump_to_i;
  logic        exc_req_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_vec_i;
  logic        irq_req_i;
  logic [31:0] irq_pc_i;
  logic [31:0] irq_vec_i;
  logic        lsu_busy_i;
  logic        mem_stall_i;
  logic        div_busy_i;
  logic        if_stall_i;
  logic        jtag_halt_i;

  jump_cause_e jump_cause_o;
  logic [31:0] jump_from_addr_o;
  logic [31:0] jump_to_addr_o;
  hold_e       hold_flag_o;
  logic        flush_o;
  logic        trap_ack_o;
  logic        trap_is_irq_o;
  logic [31:0] trap_epc_o;

  modport master (
    input  ex_jump_cause_i, ex_jump_from_i, ex_jump_to_i,
    input  exc_req_i, exc_pc_i, exc_vec_i,
    input  irq_req_i, irq_pc_i, irq_vec_i,
    input  lsu_busy_i, mem_stall_i, div_busy_i, if_stall_i, jtag_halt_i,
    output jump_cause_o, jump_from_addr_o, jump_to_addr_o, hold_flag_o,
    output flush_o, trap_ack_o, trap_is_irq_o, trap_epc_o
  );

  modport slave (
    output ex_jump_cause_i, ex_jump_from_i, ex_jump_to_i,
    output exc_req_i, exc_pc_i, exc_vec_i,
    output irq_req_i, irq_pc_i, irq_vec_i,
    output lsu_busy_i, mem_stall_i, div_busy_i, if_stall_i, jtag_halt_i,
    input  jump_cause_o, jump_from_addr_o, jump_to_addr_o, hold_flag_o,
    input  flush_o, trap_ack_o, trap_is_irq_o, trap_epc_o
  );
endinterface

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl (mispredict cycles, stall cycles, traps).
// Only compiled when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mispredict_i,
  input  logic        stall_i,
  input  logic        trap_i,
  output logic [31:0] perf_mispredict_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_trap_o
);
  logic [31:0] mis_q, mis_d, stall_q, stall_d, trap_q, trap_d;

  // Wrapping event counters
  always_comb begin
    mis_d   = mis_q   + (mispredict_i ? 32'd1 : 32'd0);
    stall_d = stall_q + (stall_i      ? 32'd1 : 32'd0);
    trap_d  = trap_q  + (trap_i       ? 32'd1 : 32'd0);
  end

  // Counter registers, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q   <= '0;
      stall_q <= '0;
      trap_q  <= '0;
    end else begin
      mis_q   <= mis_d;
      stall_q <= stall_d;
      trap_q  <= trap_d;
    end
  end

  assign perf_mispredict_o = mis_q;
  assign perf_stall_o      = stall_q;
  assign perf_trap_o       = trap_q;
endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline flow controller: arbitrates EX redirects, traps, debug halt and
// stalls into one PC/pipeline command. Trap entry runs DRAIN -> REDIRECT -> FLUSH.
// Optional counters enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned DRAIN_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_mispredict_o,
  output logic [31:0] perf_stall_o,
  output logic [31:0] perf_trap_o
`endif
);
  import pipe_ctrl_pkg::*;

  typedef enum logic [2:0] {S_RUN, S_DRAIN, S_REDIRECT, S_FLUSH, S_HALT} state_e;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  drain_cnt_q, drain_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] epc_q, epc_d, vec_q, vec_d;
  logic        is_irq_q, is_irq_d;
  jump_cause_e cause_q, cause_d;
  logic [31:0] from_q, from_d, to_q, to_d;
  hold_e       hold_q, hold_d;
  logic        flush_q, flush_d, ack_q, ack_d;

  logic        br_fwd;
  hold_e       run_hold;

  // RUN-cycle branch forwarding and stall priority
  always_comb begin
    br_fwd = !bus.mem_stall_i && (bus.ex_jump_cause_i != JC_NO) && !bus.exc_req_i;
    if (bus.mem_stall_i)     run_hold = HOLD_ALL;
    else if (bus.div_busy_i) run_hold = HOLD_ID;
    else if (bus.if_stall_i) run_hold = HOLD_IF;
    else                     run_hold = HOLD_NO;
  end

  // Next state, trap latch and counters
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    flush_cnt_d = flush_cnt_q;
    epc_d       = epc_q;
    vec_d       = vec_q;
    is_irq_d    = is_irq_q;
    case (state_q)
      S_RUN: begin
        if (bus.exc_req_i) begin
          epc_d       = bus.exc_pc_i;
          vec_d       = bus.exc_vec_i;
          is_irq_d    = 1'b0;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else if (bus.irq_req_i) begin
          // a forwarded same-cycle branch means the resume point is its target
          epc_d       = br_fwd ? bus.ex_jump_to_i : bus.irq_pc_i;
          vec_d       = bus.irq_vec_i;
          is_irq_d    = 1'b1;
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else if (bus.jtag_halt_i) begin
          state_d = S_HALT;
        end
      end
      S_DRAIN: begin
        if (!bus.lsu_busy_i || drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = S_REDIRECT;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      S_REDIRECT: begin
        flush_cnt_d = '0;
        state_d     = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + 3'd1;
        end
      end
      S_HALT: begin
        if (!bus.jtag_halt_i) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Registered outputs for the state being entered
  always_comb begin
    cause_d = JC_NO;
    from_d  = '0;
    to_d    = '0;
    hold_d  = HOLD_NO;
    flush_d = 1'b0;
    ack_d   = 1'b0;
    case (state_d)
      S_DRAIN, S_HALT: hold_d = HOLD_ALL;
      S_REDIRECT: begin
        cause_d = is_irq_d ? JC_INTERRUPT : JC_EXCEPTION;
        from_d  = epc_d;
        to_d    = vec_d;
        ack_d   = 1'b1;
      end
      S_FLUSH: flush_d = 1'b1;
      default: ;
    endcase
  end

  // State, latched trap info, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      flush_cnt_q <= '0;
      epc_q       <= '0;
      vec_q       <= '0;
      is_irq_q    <= 1'b0;
      cause_q     <= JC_NO;
      from_q      <= '0;
      to_q        <= '0;
      hold_q      <= HOLD_NO;
      flush_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      epc_q       <= epc_d;
      vec_q       <= vec_d;
      is_irq_q    <= is_irq_d;
      cause_q     <= cause_d;
      from_q      <= from_d;
      to_q        <= to_d;
      hold_q      <= hold_d;
      flush_q     <= flush_d;
      ack_q       <= ack_d;
    end
  end

  // Output select: combinational path only in RUN, registered elsewhere
  always_comb begin
    if (state_q == S_RUN) begin
      bus.jump_cause_o     = br_fwd ? bus.ex_jump_cause_i : JC_NO;
      bus.jump_from_addr_o = br_fwd ? bus.ex_jump_from_i : '0;
      bus.jump_to_addr_o   = br_fwd ? bus.ex_jump_to_i : '0;
      bus.hold_flag_o      = run_hold;
      bus.flush_o          = 1'b0;
      bus.trap_ack_o       = 1'b0;
    end else begin
      bus.jump_cause_o     = cause_q;
      bus.jump_from_addr_o = from_q;
      bus.jump_to_addr_o   = to_q;
      bus.hold_flag_o      = hold_q;
      bus.flush_o          = flush_q;
      bus.trap_ack_o       = ack_q;
    end
    bus.trap_is_irq_o = ack_q & is_irq_q;
    bus.trap_epc_o    = ack_q ? epc_q : '0;
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk               (clk),
    .rst_n             (rst_n),
    .mispredict_i      (is_mispredict(bus.jump_cause_o)),
    .stall_i           (bus.hold_flag_o != HOLD_NO),
    .trap_i            (bus.trap_ack_o),
    .perf_mispredict_o (perf_mispredict_o),
    .perf_stall_o      (perf_stall_o),
    .perf_trap_o       (perf_trap_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_mis, perf_stall, perf_trap;
`endif

  pipe_ctrl #(.FLUSH_CYCLES(2), .DRAIN_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_mispredict_o (perf_mis),
    .perf_stall_o      (perf_stall),
    .perf_trap_o       (perf_trap)
`endif
  );

  typedef struct packed {
    logic [2:0]  cause;
    logic        addr_chk;
    logic [31:0] from;
    logic [31:0] to;
    logic [1:0]  hold;
    logic        flush;
    logic        ack;
    logic        irq;
    logic [31:0] epc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input jump_cause_e c, input logic [31:0] f, input logic [31:0] t,
                              input hold_e h, input logic fl, input logic ak, input logic iq,
                              input logic [31:0] ep);
    exp_t e;
    e.cause = c; e.addr_chk = (c != JC_NO); e.from = f; e.to = t; e.hold = h;
    e.flush = fl; e.ack = ak; e.irq = iq; e.epc = ep;
    return e;
  endfunction

  exp_t e_mon;
  string t_mon;
  // Compare DUT outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      e_mon = sb_q.pop_front();
      t_mon = tag_q.pop_front();
      check_eq({t_mon, "/cause"}, 32'(bus.jump_cause_o), 32'(e_mon.cause));
      if (e_mon.addr_chk) begin
        check_eq({t_mon, "/from"}, bus.jump_from_addr_o, e_mon.from);
        check_eq({t_mon, "/to"}, bus.jump_to_addr_o, e_mon.to);
      end
      check_eq({t_mon, "/hold"}, 32'(bus.hold_flag_o), 32'(e_mon.hold));
      check_eq({t_mon, "/flush"}, 32'(bus.flush_o), 32'(e_mon.flush));
      check_eq({t_mon, "/ack"}, 32'(bus.trap_ack_o), 32'(e_mon.ack));
      check_eq({t_mon, "/is_irq"}, 32'(bus.trap_is_irq_o), 32'(e_mon.irq));
      check_eq({t_mon, "/epc"}, bus.trap_epc_o, e_mon.epc);
    end
  end

  task automatic set_idle();
    bus.ex_jump_cause_i = JC_NO;
    bus.ex_jump_from_i  = '0;
    bus.ex_jump_to_i    = '0;
    bus.exc_req_i       = 1'b0;
    bus.exc_pc_i        = '0;
    bus.exc_vec_i       = '0;
    bus.irq_req_i       = 1'b0;
    bus.irq_pc_i        = '0;
    bus.irq_vec_i       = '0;
    bus.lsu_busy_i      = 1'b0;
    bus.mem_stall_i     = 1'b0;
    bus.div_busy_i      = 1'b0;
    bus.if_stall_i      = 1'b0;
    bus.jtag_halt_i     = 1'b0;
  endtask

  task automatic tick(input string tag, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  exp_t e0, e0r, e_drain, e_flush;

  initial begin
    e0      = mk(JC_NO, '0, '0, HOLD_NO, 1'b0, 1'b0, 1'b0, '0);
    e0r     = e0;
    e0r.addr_chk = 1'b1;
    e_drain = mk(JC_NO, '0, '0, HOLD_ALL, 1'b0, 1'b0, 1'b0, '0);
    e_flush = mk(JC_NO, '0, '0, HOLD_NO, 1'b1, 1'b0, 1'b0, '0);

    rst_n = 1'b0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("reset", e0r);

    // EX branch forwarding and stall priority
    bus.ex_jump_cause_i = JC_PREDICT_NO_BUT_YES;
    bus.ex_jump_from_i  = 32'h10;
    bus.ex_jump_to_i    = 32'h100;
    tick("br_fwd", mk(JC_PREDICT_NO_BUT_YES, 32'h10, 32'h100, HOLD_NO, 1'b0, 1'b0, 1'b0, '0));
    bus.mem_stall_i = 1'b1;
    tick("br_memstall", e_drain);
    bus.mem_stall_i = 1'b0;
    bus.div_busy_i  = 1'b1;
    bus.ex_jump_cause_i = JC_PREDICT_YES_BUT_NO;
    bus.ex_jump_to_i    = 32'h104;
    tick("br_div", mk(JC_PREDICT_YES_BUT_NO, 32'h10, 32'h104, HOLD_ID, 1'b0, 1'b0, 1'b0, '0));
    bus.ex_jump_cause_i = JC_NO;
    bus.if_stall_i = 1'b1;
    tick("stall_div_if", mk(JC_NO, '0, '0, HOLD_ID, 1'b0, 1'b0, 1'b0, '0));
    bus.div_busy_i = 1'b0;
    tick("stall_if", mk(JC_NO, '0, '0, HOLD_IF, 1'b0, 1'b0, 1'b0, '0));
    set_idle();
    tick("idle", e0);

    // Exception beats interrupt, drops same-cycle branch, LSU busy 3 drain cycles
    bus.exc_req_i = 1'b1; bus.exc_pc_i = 32'h40; bus.exc_vec_i = 32'h200;
    bus.irq_req_i = 1'b1; bus.irq_pc_i = 32'h44; bus.irq_vec_i = 32'h600;
    bus.ex_jump_cause_i = JC_NOCONDITION; bus.ex_jump_from_i = 32'h3c; bus.ex_jump_to_i = 32'h300;
    tick("exc_accept", e0);
    set_idle();
    bus.lsu_busy_i = 1'b1;
    bus.ex_jump_cause_i = JC_PREDICT_NO_BUT_YES; bus.ex_jump_to_i = 32'h123;
    for (int i = 0; i < 3; i++) tick("exc_drain", e_drain);
    bus.lsu_busy_i = 1'b0;
    tick("exc_drain_last", e_drain);
    set_idle();
    tick("exc_redirect", mk(JC_EXCEPTION, 32'h40, 32'h200, HOLD_NO, 1'b0, 1'b1, 1'b0, 32'h40));
    bus.exc_req_i = 1'b1; bus.exc_pc_i = 32'h99; bus.exc_vec_i = 32'h999;
    bus.ex_jump_cause_i = JC_NOCONDITION; bus.ex_jump_to_i = 32'h55;
    for (int i = 0; i < 2; i++) tick("exc_flush", e_flush);
    set_idle();
    tick("exc_resume", e0);

    // Interrupt with same-cycle forwarded branch
    bus.irq_req_i = 1'b1; bus.irq_pc_i = 32'h74; bus.irq_vec_i = 32'h500;
    bus.ex_jump_cause_i = JC_NOCONDITION; bus.ex_jump_from_i = 32'h70; bus.ex_jump_to_i = 32'h80;
    tick("irq_br", mk(JC_NOCONDITION, 32'h70, 32'h80, HOLD_NO, 1'b0, 1'b0, 1'b0, '0));
    bus.ex_jump_cause_i = JC_NO;
    tick("irq_drain", e_drain);
    tick("irq_redirect", mk(JC_INTERRUPT, 32'h80, 32'h500, HOLD_NO, 1'b0, 1'b1, 1'b1, 32'h80));
    bus.irq_req_i = 1'b0;
    for (int i = 0; i < 2; i++) tick("irq_flush", e_flush);
    tick("irq_resume", e0);

    // Interrupt under mem stall: branch gated, epc from irq_pc
    bus.irq_req_i = 1'b1; bus.irq_pc_i = 32'h124; bus.irq_vec_i = 32'h504;
    bus.mem_stall_i = 1'b1;
    bus.ex_jump_cause_i = JC_PREDICT_NO_BUT_YES; bus.ex_jump_to_i = 32'h900;
    tick("irqs_accept", e_drain);
    bus.mem_stall_i = 1'b0; bus.ex_jump_cause_i = JC_NO;
    tick("irqs_drain", e_drain);
    tick("irqs_redirect", mk(JC_INTERRUPT, 32'h124, 32'h504, HOLD_NO, 1'b0, 1'b1, 1'b1, 32'h124));
    set_idle();
    for (int i = 0; i < 2; i++) tick("irqs_flush", e_flush);
    tick("irqs_resume", e0);

    // Drain timeout with LSU stuck busy
    bus.exc_req_i = 1'b1; bus.exc_pc_i = 32'h48; bus.exc_vec_i = 32'h208;
    bus.lsu_busy_i = 1'b1;
    tick("to_accept", e0);
    bus.exc_req_i = 1'b0;
    for (int i = 0; i < 15; i++) tick("to_drain", e_drain);
    tick("to_redirect", mk(JC_EXCEPTION, 32'h48, 32'h208, HOLD_NO, 1'b0, 1'b1, 1'b0, 32'h48));
    for (int i = 0; i < 2; i++) tick("to_flush", e_flush);
    set_idle();
    tick("to_resume", e0);

    // JTAG halt for 5 cycles
    bus.jtag_halt_i = 1'b1;
    tick("halt_req", e0);
    for (int i = 0; i < 4; i++) tick("halt", e_drain);
    bus.jtag_halt_i = 1'b0;
    tick("halt_release", e_drain);
    for (int i = 0; i < 2; i++) tick("halt_flush", e_flush);
    tick("halt_resume", e0);

    // Reset asserted mid-DRAIN
    bus.exc_req_i = 1'b1; bus.exc_pc_i = 32'h4c; bus.exc_vec_i = 32'h20c;
    bus.lsu_busy_i = 1'b1;
    tick("rst_accept", e0);
    bus.exc_req_i = 1'b0;
    tick("rst_drain", e_drain);
    rst_n = 1'b0;
    tick("rst_drain2", e_drain);
    rst_n = 1'b1;
    set_idle();
    tick("rst_after", e0r);
    tick("rst_after2", e0r);

    // Three mispredicts and one trap after the reset
    bus.ex_jump_from_i = 32'h20;
    bus.ex_jump_cause_i = JC_PREDICT_NO_BUT_YES; bus.ex_jump_to_i = 32'h140;
    tick("mp1", mk(JC_PREDICT_NO_BUT_YES, 32'h20, 32'h140, HOLD_NO, 1'b0, 1'b0, 1'b0, '0));
    bus.ex_jump_cause_i = JC_PREDICT_YES_BUT_NO; bus.ex_jump_to_i = 32'h144;
    tick("mp2", mk(JC_PREDICT_YES_BUT_NO, 32'h20, 32'h144, HOLD_NO, 1'b0, 1'b0, 1'b0, '0));
    bus.ex_jump_cause_i = JC_PREDICT_NO_BUT_YES; bus.ex_jump_to_i = 32'h148;
    tick("mp3", mk(JC_PREDICT_NO_BUT_YES, 32'h20, 32'h148, HOLD_NO, 1'b0, 1'b0, 1'b0, '0));
    set_idle();
    bus.exc_req_i = 1'b1; bus.exc_pc_i = 32'h50; bus.exc_vec_i = 32'h210;
    tick("t_accept", e0);
    set_idle();
    tick("t_drain", e_drain);
    tick("t_redirect", mk(JC_EXCEPTION, 32'h50, 32'h210, HOLD_NO, 1'b0, 1'b1, 1'b0, 32'h50));
    for (int i = 0; i < 2; i++) tick("t_flush", e_flush);
    tick("t_resume", e0);

    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_mispredict", perf_mis, 32'd3);
    check_eq("perf_trap", perf_trap, 32'd1);
    check_eq("perf_stall", perf_stall, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
